// File: rtl/multicycle_control_fsm.sv
// Control sequencer for the multicycle RV32I core: steps the shared ALU and memory
// through fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_control_fsm #(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [2:0]           ALUControl,
  output logic                 RegWrite,
  output logic [INSTRET_W-1:0] instret,
  output logic                 halted
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, HALT
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t      state, next_state;
  logic        retire;
  logic [2:0]  alu_op;
  logic        funct_ok;

  // ALU operation for R/I-type; unsupported funct3 is flagged so DECODE can halt.
  always_comb begin
    alu_op   = 3'b000;
    funct_ok = 1'b1;
    case (funct3)
      3'b000:  alu_op = (op == OP_R && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_op = 3'b101;
      3'b110:  alu_op = 3'b011;
      3'b111:  alu_op = 3'b010;
      default: funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      state <= next_state;
      if (retire) instret <= instret + INSTRET_W'(1);
    end
  end

  assign halted = (state == HALT);

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    ALUControl = 3'b000;
    RegWrite   = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) next_state = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = funct_ok ? EXECUTER : HALT;
          OP_I:         next_state = funct_ok ? EXECUTEI : HALT;
          OP_BEQ:       next_state = BEQ;
          OP_JAL:       next_state = JAL;
          default:      next_state = HALT;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ImmSrc     = (op == OP_SW) ? 2'b01 : 2'b00;
        next_state = (op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) next_state = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          next_state = FETCH;
        end
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_op;
        next_state = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_op;
        next_state = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        PCWrite    = zero;
        retire     = 1'b1;
        next_state = FETCH;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        next_state = ALUWB;
      end
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
    // Reset wins over any access in flight, including a pending store.
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule
